ahb_timer_slave: RTL

- Memory-mapped AHB-Lite timer peripheral.
- Sits downstream of ahb_interconnect as a third slave, selected by its own HSEL decode. Returns read data, ready and response to the interconnect response mux.
- Provides a prescaled free-running/auto-reload counter, a compare register, a sticky match flag and a level interrupt to the core.
- Zero-wait-state for legal transfers; two-cycle ERROR for illegal ones.

---
 rtl/ahb_timer_slave.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ahb_timer_slave.sv
// AHB-Lite timer slave: prescaled counter with compare, sticky match flag and level irq.
// Legal word transfers complete with zero wait states; bad size or alignment gets a two-cycle ERROR.
module ahb_timer_slave #(
    parameter int          CNT_W   = 32,
    parameter int          PRE_W   = 8,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic [31:0] hrdata,
    output logic        hready_out,
    output logic        hresp,
    output logic        irq
);

    localparam logic [1:0]       A_CTRL   = 2'd0;
    localparam logic [1:0]       A_COUNT  = 2'd1;
    localparam logic [1:0]       A_CMP    = 2'd2;
    localparam logic [1:0]       A_STATUS = 2'd3;
    localparam logic [CNT_W-1:0] CMP_INIT = CMP_RST[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             dp_valid_r, dp_write_r, dp_err_r;
    logic [1:0]       dp_addr_r;
    logic             ctrl_en_r, ctrl_auto_r, ctrl_irqen_r;
    logic [PRE_W-1:0] ctrl_pre_r, pre_cnt_r;
    logic [CNT_W-1:0] count_r, cmp_r;
    logic             match_r, irq_r;
    logic [31:0]      rd_s;
    logic             accept_s, err_s, wr_s, tick_s, hit_s;
    logic             unused_s;

    assign accept_s = hsel & htrans[1] & hready_in;
    assign err_s    = (hsize != 3'b010) | (haddr[1:0] != 2'b00);
    assign wr_s     = dp_valid_r & dp_write_r & ~dp_err_r & hready_in;
    assign tick_s   = ctrl_en_r & (pre_cnt_r == ctrl_pre_r);
    assign hit_s    = (count_r == cmp_r);
    assign unused_s = ^{haddr[31:4], htrans[0], hwdata};

    // Address-phase capture; held while the bus is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_err_r   <= 1'b0;
            dp_addr_r  <= 2'b00;
        end else if (hready_in) begin
            dp_valid_r <= accept_s;
            dp_write_r <= hwrite;
            dp_err_r   <= err_s;
            dp_addr_r  <= haddr[3:2];
        end
    end

    // Error response state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_OKAY;
        else        state_r <= state_s;
    end

    // Error response next state; an ERR2 cycle may accept a fresh bad transfer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_OKAY: if (accept_s && err_s) state_s = ST_ERR1; else state_s = ST_OKAY;
            ST_ERR1: state_s = ST_ERR2;
            ST_ERR2: if (accept_s && err_s) state_s = ST_ERR1; else state_s = ST_OKAY;
            default: state_s = ST_OKAY;
        endcase
    end

    // Error response outputs
    always_comb begin
        hready_out = 1'b1;
        hresp      = 1'b0;
        case (state_r)
            ST_OKAY: begin hready_out = 1'b1; hresp = 1'b0; end
            ST_ERR1: begin hready_out = 1'b0; hresp = 1'b1; end
            ST_ERR2: begin hready_out = 1'b1; hresp = 1'b1; end
            default: begin hready_out = 1'b1; hresp = 1'b0; end
        endcase
    end

    // Control and compare registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en_r    <= 1'b0;
            ctrl_auto_r  <= 1'b0;
            ctrl_irqen_r <= 1'b0;
            ctrl_pre_r   <= {PRE_W{1'b0}};
            cmp_r        <= CMP_INIT;
        end else if (wr_s) begin
            if (dp_addr_r == A_CTRL) begin
                ctrl_en_r    <= hwdata[0];
                ctrl_auto_r  <= hwdata[1];
                ctrl_irqen_r <= hwdata[2];
                ctrl_pre_r   <= hwdata[8 +: PRE_W];
            end
            if (dp_addr_r == A_CMP) cmp_r <= hwdata[CNT_W-1:0];
        end
    end

    // Prescaler: restarts from zero whenever the timer is disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          pre_cnt_r <= {PRE_W{1'b0}};
        else if (!ctrl_en_r) pre_cnt_r <= {PRE_W{1'b0}};
        else if (tick_s)     pre_cnt_r <= {PRE_W{1'b0}};
        else                 pre_cnt_r <= pre_cnt_r + PRE_ONE;
    end

    // Counter; a bus write wins over the tick, the match flag is set on the compare tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
            match_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            if (wr_s && (dp_addr_r == A_COUNT))  count_r <= hwdata[CNT_W-1:0];
            else if (tick_s && hit_s && ctrl_auto_r) count_r <= {CNT_W{1'b0}};
            else if (tick_s)                     count_r <= count_r + CNT_ONE;
            if (tick_s && hit_s)                 match_r <= 1'b1;
            else if (wr_s && (dp_addr_r == A_STATUS) && hwdata[0]) match_r <= 1'b0;
            irq_r <= match_r & ctrl_irqen_r;
        end
    end

    // Read mux over the captured address
    always_comb begin
        rd_s = 32'h0000_0000;
        case (dp_addr_r)
            A_CTRL: begin
                rd_s[0]          = ctrl_en_r;
                rd_s[1]          = ctrl_auto_r;
                rd_s[2]          = ctrl_irqen_r;
                rd_s[8 +: PRE_W] = ctrl_pre_r;
            end
            A_COUNT:  rd_s[CNT_W-1:0] = count_r;
            A_CMP:    rd_s[CNT_W-1:0] = cmp_r;
            A_STATUS: rd_s[0]         = match_r;
            default:  rd_s            = 32'h0000_0000;
        endcase
    end

    assign hrdata = (dp_valid_r & ~dp_write_r & ~dp_err_r) ? rd_s : 32'h0000_0000;
    assign irq    = irq_r;

endmodule
